// File: rtl/axi_lite_fifo_slave_pkg.sv
// Shared AXI4-Lite types, register map and response codes for the FIFO slave.
// Also holds the FSM state enums and the register decoder used by the top.
package axi_lite_fifo_slave_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [STRB_W-1:0] strb_t;
  typedef logic [1:0]        resp_t;
  typedef logic [3:0]        cach_t;
  typedef logic [2:0]        prot_t;

  localparam addr_t DATA_OFS   = addr_t'('h0);
  localparam addr_t STATUS_OFS = addr_t'('h4);
  localparam addr_t CTRL_OFS   = addr_t'('h8);

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  localparam addr_t ADDR_LSB_MASK = addr_t'(STRB_W - 1);

  typedef enum logic [1:0] {REG_DATA, REG_STATUS, REG_CTRL, REG_NONE} reg_e;
  typedef enum logic {W_IDLE, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_RESP} rstate_e;

  // Byte-lane bits are dropped so any address within a word hits that word.
  function automatic reg_e decode_reg(input addr_t a);
    addr_t al;
    reg_e  r;
    al = a & ~ADDR_LSB_MASK;
    case (al)
      DATA_OFS:   r = REG_DATA;
      STATUS_OFS: r = REG_STATUS;
      CTRL_OFS:   r = REG_CTRL;
      default:    r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/axi_lite_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers, registered empty/full flags and a
// combinational head-of-queue output.
module axi_lite_sync_fifo
  import axi_lite_fifo_slave_pkg::*;
#(
  parameter  int unsigned FIFO_DEPTH = 16,
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  data_t            wdata,
  output data_t            rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int unsigned IDX_W = CNT_W - 1;

  data_t            mem [FIFO_DEPTH];
  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] rd_ptr;
  logic [CNT_W-1:0] wr_ptr_nxt;
  logic [CNT_W-1:0] rd_ptr_nxt;
  logic             push_ok;
  logic             pop_ok;

  always_comb begin
    push_ok    = push && !full;
    pop_ok     = pop && !empty;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
    end else begin
      if (push_ok) wr_ptr_nxt = wr_ptr + CNT_W'(1);
      if (pop_ok)  rd_ptr_nxt = rd_ptr + CNT_W'(1);
    end
  end

  // Flags are derived from the next pointers so they land on the same edge.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      empty  <= (wr_ptr_nxt == rd_ptr_nxt);
      full   <= (wr_ptr_nxt[CNT_W-1] != rd_ptr_nxt[CNT_W-1]) &&
                (wr_ptr_nxt[IDX_W-1:0] == rd_ptr_nxt[IDX_W-1:0]);
    end
  end

  always_ff @(posedge ACLK) begin
    if (push_ok && !flush) mem[wr_ptr[IDX_W-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[IDX_W-1:0]];
  assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/axi_lite_fifo_slave.sv
// AXI4-Lite slave exposing a FIFO through DATA/STATUS/CTRL registers, with
// independent write (AW+W -> B) and read (AR -> R) state machines.
module axi_lite_fifo_slave
  import axi_lite_fifo_slave_pkg::*;
#(
  parameter  int unsigned FIFO_DEPTH = 16,
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic  ACLK,
  input  logic  ARESETN,
  input  addr_t AWADDR,
  input  cach_t AWCACHE,
  input  prot_t AWPROT,
  input  logic  AWVALID,
  output logic  AWREADY,
  input  data_t WDATA,
  input  strb_t WSTRB,
  input  logic  WVALID,
  output logic  WREADY,
  output resp_t BRESP,
  output logic  BVALID,
  input  logic  BREADY,
  input  addr_t ARADDR,
  input  cach_t ARCACHE,
  input  prot_t ARPROT,
  input  logic  ARVALID,
  output logic  ARREADY,
  output data_t RDATA,
  output resp_t RRESP,
  output logic  RVALID,
  input  logic  RREADY,
  output logic  fifo_empty,
  output logic  fifo_full
);

  wstate_e          wstate;
  wstate_e          wstate_nxt;
  rstate_e          rstate;
  rstate_e          rstate_nxt;
  logic             aw_held;
  logic             w_held;
  addr_t            awaddr_q;
  data_t            wdata_q;
  logic             wstrb0_q;
  resp_t            bresp_nxt;
  data_t            rdata_nxt;
  resp_t            rresp_nxt;
  logic             push;
  logic             pop;
  logic             flush;
  data_t            fifo_rdata;
  logic [CNT_W-1:0] fifo_count;
  data_t            status_word;
  logic             unused_ok;

  assign unused_ok = &{1'b0, AWCACHE, AWPROT, ARCACHE, ARPROT, WSTRB[STRB_W-1:1]};

  axi_lite_sync_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wdata   (wdata_q),
    .rdata   (fifo_rdata),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_comb begin
    status_word              = '0;
    status_word[0]           = fifo_empty;
    status_word[1]           = fifo_full;
    status_word[8 +: CNT_W]  = fifo_count;
  end

  assign AWREADY = (wstate == W_IDLE) && !aw_held;
  assign WREADY  = (wstate == W_IDLE) && !w_held;
  assign BVALID  = (wstate == W_RESP);
  assign ARREADY = (rstate == R_IDLE);
  assign RVALID  = (rstate == R_RESP);

  always_comb begin
    wstate_nxt = wstate;
    push       = 1'b0;
    flush      = 1'b0;
    bresp_nxt  = RESP_OKAY;
    case (wstate)
      W_IDLE: begin
        if (aw_held && w_held) begin
          wstate_nxt = W_RESP;
          case (decode_reg(awaddr_q))
            REG_DATA: begin
              if (fifo_full) bresp_nxt = RESP_SLVERR;
              else           push      = 1'b1;
            end
            REG_STATUS: bresp_nxt = RESP_SLVERR;
            REG_CTRL:   flush     = wdata_q[0] && wstrb0_q;
            default:    bresp_nxt = RESP_DECERR;
          endcase
        end
      end
      W_RESP: begin
        if (BREADY) wstate_nxt = W_IDLE;
      end
      default: wstate_nxt = W_IDLE;
    endcase
  end

  // AW and W are latched independently; the op runs once both are held.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wstate   <= W_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb0_q <= 1'b0;
      BRESP    <= RESP_OKAY;
    end else begin
      wstate <= wstate_nxt;
      if (AWVALID && AWREADY) begin
        aw_held  <= 1'b1;
        awaddr_q <= AWADDR;
      end
      if (WVALID && WREADY) begin
        w_held   <= 1'b1;
        wdata_q  <= WDATA;
        wstrb0_q <= WSTRB[0];
      end
      if (wstate == W_IDLE && aw_held && w_held) BRESP <= bresp_nxt;
      if (BVALID && BREADY) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  always_comb begin
    rstate_nxt = rstate;
    pop        = 1'b0;
    rdata_nxt  = '0;
    rresp_nxt  = RESP_OKAY;
    case (rstate)
      R_IDLE: begin
        if (ARVALID) begin
          rstate_nxt = R_RESP;
          case (decode_reg(ARADDR))
            REG_DATA: begin
              if (fifo_empty) begin
                rresp_nxt = RESP_SLVERR;
              end else begin
                rdata_nxt = fifo_rdata;
                pop       = 1'b1;
              end
            end
            REG_STATUS: rdata_nxt = status_word;
            REG_CTRL:   rdata_nxt = '0;
            default:    rresp_nxt = RESP_DECERR;
          endcase
        end
      end
      R_RESP: begin
        if (RREADY) rstate_nxt = R_IDLE;
      end
      default: rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rstate <= R_IDLE;
      RDATA  <= '0;
      RRESP  <= RESP_OKAY;
    end else begin
      rstate <= rstate_nxt;
      if (rstate == R_IDLE && ARVALID) begin
        RDATA <= rdata_nxt;
        RRESP <= rresp_nxt;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_fifo_slave.sv
// Self-checking bench: a queue-based register model predicts every response,
// a negedge monitor compares outputs each cycle, directed cases pin the model.
module tb_axi_lite_fifo_slave;
  import axi_lite_fifo_slave_pkg::*;

  localparam int DEPTH = 16;

  logic  ACLK = 1'b0;
  logic  ARESETN = 1'b0;
  addr_t AWADDR;
  cach_t AWCACHE;
  prot_t AWPROT;
  logic  AWVALID;
  logic  AWREADY;
  data_t WDATA;
  strb_t WSTRB;
  logic  WVALID;
  logic  WREADY;
  resp_t BRESP;
  logic  BVALID;
  logic  BREADY;
  addr_t ARADDR;
  cach_t ARCACHE;
  prot_t ARPROT;
  logic  ARVALID;
  logic  ARREADY;
  data_t RDATA;
  resp_t RRESP;
  logic  RVALID;
  logic  RREADY;
  logic  fifo_empty;
  logic  fifo_full;

  always #5 ACLK = ~ACLK;

  axi_lite_fifo_slave #(.FIFO_DEPTH(DEPTH)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full)
  );

  int    n_chk = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    inflight = 0;
  bit    chk_en = 0;
  data_t mq[$];
  data_t exp_rdata;
  resp_t exp_rresp;
  resp_t exp_bresp;

  always @(posedge ACLK) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got no handshake expected one within 50 cycles at %0t", name, $time);
  endtask

  // 0 DATA, 1 STATUS, 2 CTRL, 3 unmapped
  function automatic int reg_of(input addr_t a);
    addr_t al;
    al = a & 32'hFFFF_FFFC;
    if (al == 32'h0) return 0;
    if (al == 32'h4) return 1;
    if (al == 32'h8) return 2;
    return 3;
  endfunction

  function automatic void model_write(input addr_t a, input data_t d, input strb_t s, output resp_t r);
    case (reg_of(a))
      0: begin
        if (mq.size() < DEPTH) begin mq.push_back(d); r = 2'b00; end
        else r = 2'b10;
      end
      1: r = 2'b10;
      2: begin
        if (d[0] && s[0]) mq.delete();
        r = 2'b00;
      end
      default: r = 2'b11;
    endcase
  endfunction

  function automatic void model_read(input addr_t a, output data_t d, output resp_t r);
    d = 0;
    r = 2'b00;
    case (reg_of(a))
      0: begin
        if (mq.size() > 0) d = mq.pop_front();
        else r = 2'b10;
      end
      1: d = (32'(mq.size()) << 8) | ((mq.size() == DEPTH) ? 32'h2 : 32'h0) |
             ((mq.size() == 0) ? 32'h1 : 32'h0);
      2: d = 0;
      default: r = 2'b11;
    endcase
  endfunction

  always @(negedge ACLK) begin
    if (ARESETN && chk_en) begin
      if (RVALID) begin
        check("mon_rdata", RDATA, exp_rdata);
        check("mon_rresp", 32'(RRESP), 32'(exp_rresp));
      end
      if (BVALID) check("mon_bresp", 32'(BRESP), 32'(exp_bresp));
      if (inflight == 0) begin
        check("mon_empty", 32'(fifo_empty), 32'(mq.size() == 0));
        check("mon_full", 32'(fifo_full), 32'(mq.size() == DEPTH));
      end
    end
  end

  task automatic do_write(input addr_t a, input data_t d, input strb_t s, input int aw_dly,
                          input int w_dly, input int b_dly, input bit use_model,
                          output resp_t r, output int lat);
    int t_aw;
    int k;
    inflight++;
    if (use_model) model_write(a, d, s, exp_bresp);
    t_aw = cyc;
    fork
      begin
        int ka = 0;
        repeat (aw_dly) @(negedge ACLK);
        AWADDR = a; AWVALID = 1'b1;
        while (!AWREADY && ka < 50) begin @(negedge ACLK); ka++; end
        if (!AWREADY) timeout_fail("aw_handshake");
        @(negedge ACLK);
        AWVALID = 1'b0;
        t_aw = cyc;
      end
      begin
        int kw = 0;
        repeat (w_dly) @(negedge ACLK);
        WDATA = d; WSTRB = s; WVALID = 1'b1;
        while (!WREADY && kw < 50) begin @(negedge ACLK); kw++; end
        if (!WREADY) timeout_fail("w_handshake");
        @(negedge ACLK);
        WVALID = 1'b0;
      end
    join
    k = 0;
    while (!BVALID && k < 50) begin @(negedge ACLK); k++; end
    if (!BVALID) timeout_fail("b_valid");
    lat = cyc - t_aw;
    repeat (b_dly) begin
      check("b_hold_bvalid", 32'(BVALID), 32'h1);
      check("b_hold_awready", 32'(AWREADY), 32'h0);
      check("b_hold_wready", 32'(WREADY), 32'h0);
      @(negedge ACLK);
    end
    r = BRESP;
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    inflight--;
  endtask

  task automatic do_read(input addr_t a, input int ar_dly, input int r_dly, input bit use_model,
                         output data_t d, output resp_t r);
    int k;
    inflight++;
    if (use_model) model_read(a, exp_rdata, exp_rresp);
    repeat (ar_dly) @(negedge ACLK);
    ARADDR = a; ARVALID = 1'b1;
    k = 0;
    while (!ARREADY && k < 50) begin @(negedge ACLK); k++; end
    if (!ARREADY) timeout_fail("ar_handshake");
    @(negedge ACLK);
    ARVALID = 1'b0;
    k = 0;
    while (!RVALID && k < 50) begin @(negedge ACLK); k++; end
    if (!RVALID) timeout_fail("r_valid");
    repeat (r_dly) @(negedge ACLK);
    d = RDATA;
    r = RRESP;
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
    inflight--;
  endtask

  initial begin
    resp_t r;
    resp_t r2;
    data_t d;
    int    lat;
    AWADDR = '0; AWCACHE = '0; AWPROT = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARCACHE = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b0;
    repeat (3) @(negedge ACLK);
    check("rst_awready", 32'(AWREADY), 32'h1);
    check("rst_wready", 32'(WREADY), 32'h1);
    check("rst_arready", 32'(ARREADY), 32'h1);
    check("rst_bvalid", 32'(BVALID), 32'h0);
    check("rst_rvalid", 32'(RVALID), 32'h0);
    check("rst_rdata", RDATA, 32'h0);
    check("rst_empty", 32'(fifo_empty), 32'h1);
    check("rst_full", 32'(fifo_full), 32'h0);
    ARESETN = 1'b1;
    @(negedge ACLK);
    chk_en = 1'b1;

    do_read(32'h4, 0, 0, 1, d, r);
    check("status_reset", d, 32'h1);
    check("status_reset_resp", 32'(r), 32'h0);

    do_write(32'h0, 32'hA5A5_0001, 4'hF, 0, 0, 0, 1, r, lat);
    check("wr1_resp", 32'(r), 32'h0);
    do_write(32'h0, 32'hA5A5_0002, 4'h0, 1, 0, 1, 1, r, lat);
    check("wr2_resp", 32'(r), 32'h0);
    do_read(32'h0, 0, 2, 1, d, r);
    check("rd1_data", d, 32'hA5A5_0001);
    do_read(32'h0, 1, 0, 1, d, r);
    check("rd2_data", d, 32'hA5A5_0002);
    check("rd2_resp", 32'(r), 32'h0);
    do_read(32'h4, 0, 0, 1, d, r);
    check("status_drained", d, 32'h1);

    for (int i = 0; i < DEPTH; i++) do_write(32'h0, 32'h1000_0000 + i, 4'hF, 0, 0, 0, 1, r, lat);
    check("fill_full_flag", 32'(fifo_full), 32'h1);
    do_read(32'h4, 0, 0, 1, d, r);
    check("status_full", d, 32'h1002);
    do_write(32'h0, 32'hBAD0_0017, 4'hF, 0, 0, 0, 1, r, lat);
    check("overflow_resp", 32'(r), 32'h2);
    do_read(32'h4, 0, 0, 1, d, r);
    check("status_after_overflow", d, 32'h1002);

    // Full FIFO: push and pop land on the same edge.
    exp_bresp = RESP_SLVERR; exp_rdata = 32'h1000_0000; exp_rresp = RESP_OKAY;
    fork
      do_write(32'h0, 32'hDEAD_0000, 4'hF, 0, 0, 0, 0, r, lat);
      do_read(32'h0, 1, 0, 0, d, r2);
    join
    void'(mq.pop_front());
    check("full_pushpop_bresp", 32'(r), 32'h2);
    check("full_pushpop_rdata", d, 32'h1000_0000);
    check("full_pushpop_rresp", 32'(r2), 32'h0);
    while (mq.size() > 0) do_read(32'h0, 0, $urandom_range(0, 1), 1, d, r);
    do_read(32'h0, 0, 0, 1, d, r);
    check("empty_rdata", d, 32'h0);
    check("empty_rresp", 32'(r), 32'h2);

    // Empty FIFO: pop fails, concurrent push succeeds.
    exp_bresp = RESP_OKAY; exp_rdata = 32'h0; exp_rresp = RESP_SLVERR;
    fork
      do_write(32'h0, 32'h5555_AAAA, 4'hF, 0, 0, 0, 0, r, lat);
      do_read(32'h0, 1, 0, 0, d, r2);
    join
    mq.push_back(32'h5555_AAAA);
    check("empty_pushpop_bresp", 32'(r), 32'h0);
    check("empty_pushpop_rresp", 32'(r2), 32'h2);
    do_read(32'h0, 0, 0, 1, d, r);
    check("empty_pushpop_readback", d, 32'h5555_AAAA);

    do_write(32'h0, 32'hC0DE_0003, 4'hF, 3, 0, 4, 1, r, lat);
    check("w_first_latency", 32'(lat), 32'h1);
    check("w_first_resp", 32'(r), 32'h0);
    do_read(32'h0, 0, 0, 1, d, r);

    for (int i = 0; i < 5; i++) do_write(32'h0, 32'h2000_0000 + i, 4'hF, 0, 0, 0, 1, r, lat);
    do_write(32'h8, 32'h1, 4'h1, 0, 0, 0, 1, r, lat);
    check("flush_resp", 32'(r), 32'h0);
    do_read(32'h4, 0, 0, 1, d, r);
    check("status_flushed", d, 32'h1);
    do_write(32'hC, 32'h1234_5678, 4'hF, 0, 0, 0, 1, r, lat);
    check("decerr_bresp", 32'(r), 32'h3);
    do_read(32'hC, 0, 0, 1, d, r);
    check("decerr_rresp", 32'(r), 32'h3);
    check("decerr_rdata", d, 32'h0);
    do_write(32'h4, 32'h1, 4'hF, 0, 0, 0, 1, r, lat);
    check("status_write_resp", 32'(r), 32'h2);

    // Flush and pop on the same edge: pop sees the old head.
    for (int i = 0; i < 3; i++) do_write(32'h0, 32'h3000_0000 + i, 4'hF, 0, 0, 0, 1, r, lat);
    exp_bresp = RESP_OKAY; exp_rdata = 32'h3000_0000; exp_rresp = RESP_OKAY;
    fork
      do_write(32'h8, 32'h1, 4'hF, 0, 0, 0, 0, r, lat);
      do_read(32'h0, 1, 0, 0, d, r2);
    join
    mq.delete();
    check("flushpop_rdata", d, 32'h3000_0000);
    check("flushpop_empty", 32'(fifo_empty), 32'h1);

    for (int i = 0; i < 400; i++) begin
      int    sel;
      int    wb;
      addr_t a;
      sel = $urandom_range(0, 99);
      wb  = ((i / 40) % 2 == 0) ? 65 : 30;
      if (sel < 4) begin
        a = 32'h8 | 32'($urandom_range(0, 3));
        do_write(a, $urandom, strb_t'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                 $urandom_range(0, 2), 1, r, lat);
      end else if (sel < 8) begin
        case ($urandom_range(0, 2))
          0: a = 32'h4;
          1: a = 32'hC;
          default: a = 32'h100;
        endcase
        do_write(a, $urandom, 4'hF, 0, $urandom_range(0, 2), 0, 1, r, lat);
      end else if (sel < 14) begin
        a = 32'h4 << $urandom_range(0, 2);
        do_read(a, $urandom_range(0, 1), $urandom_range(0, 2), 1, d, r);
      end else if (sel < 14 + wb) begin
        do_write(32'($urandom_range(0, 3)), $urandom, strb_t'($urandom), $urandom_range(0, 2),
                 $urandom_range(0, 2), $urandom_range(0, 2), 1, r, lat);
      end else begin
        do_read(32'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 2), 1, d, r);
      end
    end

    while (mq.size() < 2) do_write(32'h0, $urandom, 4'hF, 0, 0, 0, 1, r, lat);
    chk_en = 1'b0;
    ARADDR = 32'h4; ARVALID = 1'b1;
    @(negedge ACLK);
    ARVALID = 1'b0;
    check("pre_reset_rvalid", 32'(RVALID), 32'h1);
    #2 ARESETN = 1'b0;
    #1;
    check("async_rst_rvalid", 32'(RVALID), 32'h0);
    check("async_rst_empty", 32'(fifo_empty), 32'h1);
    check("async_rst_arready", 32'(ARREADY), 32'h1);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    mq.delete();
    @(negedge ACLK);
    chk_en = 1'b1;
    do_read(32'h4, 0, 0, 1, d, r);
    check("status_after_reset_pulse", d, 32'h1);

    repeat (2) @(negedge ACLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
